// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU,
//            with a single-cycle path for divide-by-zero and signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic            flush_ex,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] y,
    output logic            done,
    output logic            busy
);

    localparam int                  c_CNT_W   = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0]  c_LAST    = c_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]     c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [XLEN-1:0]     r_q;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_div;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_want_rem;
    logic                r_q_neg;
    logic                r_r_neg;
    logic [XLEN-1:0]     r_y;

    logic                w_is_signed;
    logic                w_want_rem;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_div0;
    logic                w_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_y;
    logic                w_accept;
    logic [XLEN:0]       w_trial;
    logic [XLEN-1:0]     w_fix_y;
    logic                w_unused;

    // funct3[2] only marks the M-extension divide group; the unit never decodes it
    assign w_unused    = funct3[2];

    assign w_is_signed = ~funct3[0];
    assign w_want_rem  = funct3[1];
    assign w_neg_a     = w_is_signed & a[XLEN-1];
    assign w_neg_b     = w_is_signed & b[XLEN-1];
    assign w_abs_a     = w_neg_a ? -a : a;
    assign w_abs_b     = w_neg_b ? -b : b;

    assign w_div0      = (b == '0);
    assign w_ovf       = w_is_signed & (a == c_INT_MIN) & (b == '1);
    assign w_fast      = w_div0 | w_ovf;
    assign w_fast_y    = w_want_rem ? (w_div0 ? a  : '0)
                                    : (w_div0 ? '1 : c_INT_MIN);

    assign w_accept    = valid & ~flush_ex &
                         ((r_state == S_IDLE) | (r_state == S_DONE));

    // Bit XLEN of the trial difference is the borrow: set means "does not fit"
    assign w_trial     = {r_rem, r_q[XLEN-1]} - {1'b0, r_div};
    assign w_fix_y     = r_want_rem ? (r_r_neg ? -r_rem : r_rem)
                                    : (r_q_neg ? -r_q   : r_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush_ex) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (valid) begin
                        w_next_state = w_fast ? S_DONE : S_CALC;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_cnt == c_LAST) begin
                        w_next_state = S_FIX;
                    end
                end
                S_FIX:   w_next_state = S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q        <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_want_rem <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_y        <= '0;
        end else if (w_accept) begin
            if (w_fast) begin
                r_y <= w_fast_y;
            end else begin
                r_q        <= w_abs_a;
                r_div      <= w_abs_b;
                r_rem      <= '0;
                r_cnt      <= '0;
                r_want_rem <= w_want_rem;
                r_q_neg    <= w_neg_a ^ w_neg_b;
                r_r_neg    <= w_neg_a;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (!w_trial[XLEN]) begin
                r_rem <= w_trial[XLEN-1:0];
                r_q   <= {r_q[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= {r_rem[XLEN-2:0], r_q[XLEN-1]};
                r_q   <= {r_q[XLEN-2:0], 1'b0};
            end
        end else if ((r_state == S_FIX) && !flush_ex) begin
            r_y <= w_fix_y;
        end
    end

    assign y    = r_y;
    assign done = (r_state == S_DONE);
    assign busy = (r_state == S_CALC) | (r_state == S_FIX);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed self-checking bench for div_unit (latency, results,
//            fast paths, flush, back-to-back issue and mid-operation reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        flush_ex;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic [31:0] y;
    logic        done;
    logic        busy;

    int n_checks;
    int n_fail;
    int cyc;
    int t0;

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .flush_ex (flush_ex),
        .a        (a),
        .b        (b),
        .funct3   (funct3),
        .y        (y),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drives valid for one cycle; on return the bench sits in cycle 1 of the op
    task automatic start_op(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb);
        @(posedge clk);
        #1;
        funct3 = f;
        a      = aa;
        b      = bb;
        valid  = 1'b1;
        t0     = cyc;
        @(posedge clk);
        #1;
        valid  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic [31:0] yv);
        lat = -1;
        yv  = 32'h0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - t0;
                yv  = y;
                return;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks += 3;
        if (y !== 32'h0)  begin n_fail++; $display("FAIL reset_y: got %h expected 00000000", y); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_signed;
        int          lat;
        logic [31:0] yv;
        start_op(F_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, yv);
        n_checks += 2;
        if (lat !== 34) begin n_fail++; $display("FAIL div_latency: got %0d expected 34", lat); end
        if (yv !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2: got %h expected fffffffd", yv); end
        start_op(F_REM, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, yv);
        n_checks++;
        if (yv !== 32'h1) begin n_fail++; $display("FAIL rem_7_m2: got %h expected 00000001", yv); end
        start_op(F_REM, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, yv);
        n_checks++;
        if (yv !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2: got %h expected ffffffff", yv); end
    endtask

    task automatic test_unsigned;
        int          lat;
        logic [31:0] yv;
        start_op(F_DIVU, 32'hFFFF_FFFF, 32'h10);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            n_checks += 2;
            if (busy !== (k <= 33)) begin
                n_fail++;
                $display("FAIL divu_busy_c%0d: got %b expected %b", k, busy, (k <= 33));
            end
            if (done !== (k == 34)) begin
                n_fail++;
                $display("FAIL divu_done_c%0d: got %b expected %b", k, done, (k == 34));
            end
            if (k == 34) begin
                n_checks++;
                if (y !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL divu_ffff_16: got %h expected 0fffffff", y); end
            end
        end
        start_op(F_REMU, 32'hFFFF_FFFF, 32'h10);
        wait_done(lat, yv);
        n_checks++;
        if (yv !== 32'hF) begin n_fail++; $display("FAIL remu_ffff_16: got %h expected 0000000f", yv); end
    endtask

    task automatic test_div_zero;
        int          lat;
        logic [31:0] yv;
        start_op(F_DIV, 32'd5, 32'd0);
        wait_done(lat, yv);
        n_checks += 3;
        if (lat !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d expected 1", lat); end
        if (yv !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_q: got %h expected ffffffff", yv); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL div0_busy: got %b expected 0", busy); end
        start_op(F_REMU, 32'h1234_5678, 32'd0);
        wait_done(lat, yv);
        n_checks += 3;
        if (lat !== 1) begin n_fail++; $display("FAIL rem0_latency: got %0d expected 1", lat); end
        if (yv !== 32'h1234_5678) begin n_fail++; $display("FAIL rem0_r: got %h expected 12345678", yv); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rem0_busy: got %b expected 0", busy); end
    endtask

    task automatic test_overflow;
        int          lat;
        logic [31:0] yv;
        start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, yv);
        n_checks += 2;
        if (lat !== 1) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 1", lat); end
        if (yv !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_q: got %h expected 80000000", yv); end
        start_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, yv);
        n_checks++;
        if (yv !== 32'h0) begin n_fail++; $display("FAIL ovf_r: got %h expected 00000000", yv); end
        start_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, yv);
        n_checks += 2;
        if (lat !== 34) begin n_fail++; $display("FAIL ovf_divu_latency: got %0d expected 34", lat); end
        if (yv !== 32'h0) begin n_fail++; $display("FAIL ovf_divu_q: got %h expected 00000000", yv); end
    endtask

    task automatic test_mixed;
        int          lat;
        logic [31:0] yv;
        logic [2:0]  f_tab [6] = '{F_DIVU, F_REMU, F_DIV, F_REM, F_DIV, F_REM};
        logic [31:0] a_tab [6] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100};
        logic [31:0] b_tab [6] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] e_tab [6] = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'd14, 32'd2};
        for (int i = 0; i < 6; i++) begin
            start_op(f_tab[i], a_tab[i], b_tab[i]);
            wait_done(lat, yv);
            n_checks++;
            if (yv !== e_tab[i]) begin
                n_fail++;
                $display("FAIL mixed_%0d: got %h expected %h", i, yv, e_tab[i]);
            end
        end
    endtask

    // Entry y is 2 (from REM 100 / -7)
    task automatic test_flush;
        int          lat;
        logic [31:0] yv;
        start_op(F_DIVU, 32'h7FFF_FFFF, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        flush_ex = 1'b1;
        @(posedge clk);
        #1;
        flush_ex = 1'b0;
        funct3   = F_DIVU;
        a        = 32'd1000;
        b        = 32'd10;
        valid    = 1'b1;
        t0       = cyc;
        @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b expected 0", done); end
        if (y !== 32'd2) begin n_fail++; $display("FAIL flush_y_held: got %h expected 00000002", y); end
        @(posedge clk);
        #1;
        valid = 1'b0;
        wait_done(lat, yv);
        n_checks += 2;
        if (lat !== 34) begin n_fail++; $display("FAIL flush_next_latency: got %0d expected 34", lat); end
        if (yv !== 32'd100) begin n_fail++; $display("FAIL flush_next_q: got %h expected 00000064", yv); end
    endtask

    task automatic test_back_to_back;
        int          lat;
        logic [31:0] yv;
        start_op(F_DIVU, 32'd1000, 32'd10);
        repeat (4) begin @(posedge clk); #1; end
        funct3 = F_DIV;
        a      = 32'd5;
        b      = 32'd0;
        valid  = 1'b1;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        wait_done(lat, yv);
        n_checks += 2;
        if (lat !== 34) begin n_fail++; $display("FAIL busy_drop_latency: got %0d expected 34", lat); end
        if (yv !== 32'd100) begin n_fail++; $display("FAIL busy_drop_q: got %h expected 00000064", yv); end
        funct3 = F_DIVU;
        a      = 32'd1000;
        b      = 32'd3;
        valid  = 1'b1;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        wait_done(lat, yv);
        n_checks += 2;
        if (lat !== 68) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 68", lat); end
        if (yv !== 32'd333) begin n_fail++; $display("FAIL b2b_q: got %h expected 0000014d", yv); end
    endtask

    task automatic test_reset_mid;
        int n_done;
        start_op(F_DIVU, 32'hFFFF_FFFF, 32'd7);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        n_checks += 3;
        if (y !== 32'h0)  begin n_fail++; $display("FAIL rst_mid_y: got %h expected 00000000", y); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d expected 0", n_done); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        t0       = 0;
        rst      = 1'b0;
        valid    = 1'b0;
        flush_ex = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        funct3   = 3'b000;
        repeat (3) @(posedge clk);
        test_reset;
        test_signed;
        test_unsigned;
        test_div_zero;
        test_overflow;
        test_mixed;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions; the counterpart of the multiply path in the execute stage.
- Accepts one operation on a valid pulse and takes absolute values of signed operands.
- Runs a 32-step restoring division, applies sign fix-up, and returns a registered 32-bit result with a one-cycle done pulse.
- Handles divide-by-zero and signed overflow per the RISC-V spec in a 1-cycle fast path.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the counter is sized $clog2(XLEN)+1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- valid  input  1  start request; operands and funct3 are sampled on the same edge
- flush_ex  input  1  kill the in-flight operation (execute-stage flush)
- a  input  32  dividend
- b  input  32  divisor
- funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- y  output  32  result (quotient or remainder); held until the next accepted operation
- done  output  1  one-cycle pulse; y is valid in this cycle
- busy  output  1  high in CALC and FIX; valid is ignored while high

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; y=0, done=0, busy=0; quotient, remainder and counter cleared.
- Decode:
  - is_signed = ~funct3[0]; want_rem = funct3[1].
  - neg_a = is_signed & a[31]; neg_b = is_signed & b[31].
  - |a| = neg_a ? -a : a; |b| = neg_b ? -b : b (32-bit two's complement; -0x80000000 = 0x80000000, which is correct as unsigned).
  - q_neg = neg_a ^ neg_b; r_neg = neg_a.
- States: IDLE, CALC, FIX, DONE.
- Acceptance and fast path:
  - An operation is accepted when valid=1, flush_ex=0 and state is IDLE or DONE.
  - Fast-path case b==0: y = want_rem ? a : 32'hFFFFFFFF.
  - Fast-path case signed overflow (is_signed, a==32'h80000000, b==32'hFFFFFFFF): y = want_rem ? 0 : 32'h80000000.
  - On a fast-path case, the next state is DONE, y is registered on the accept edge, and done=1 in cycle 1.
  - Otherwise, the next state is CALC: latch |a| into the quotient shift register, |b| into the divisor register, remainder=0, counter=0, and latch want_rem, q_neg and r_neg.
- CALC, one step per cycle, 32 cycles:
  - Form the 33-bit trial {rem[31:0], q[31]} - {1'b0, div}.
  - If the trial is non-negative: rem = trial[31:0], shift 1 into q.
  - Else: rem = {rem[30:0], q[31]}, shift 0 into q.
  - Go to FIX when counter==31 on that edge.
- FIX: y = want_rem ? (r_neg ? -rem : rem) : (q_neg ? -q : q); next state DONE.
- DONE: done=1 for exactly this cycle. Next state is IDLE, unless a new valid is accepted (back-to-back issue allowed).
- Latency, normal path: valid in cycle 0 → CALC in cycles 1..32 → FIX in cycle 33 → done=1 in cycle 34. Fast path: done=1 in cycle 1.
- busy = (state==CALC) | (state==FIX). valid while busy is dropped, not queued.
- flush_ex=1 in any state:
  - Next state IDLE, done=0 next cycle, y unchanged.
  - flush_ex and valid in the same cycle: flush wins and the operation is not accepted.
- Asynchronous reset mid-CALC aborts immediately; no done is produced.
- Quotient and remainder satisfy a = q*b + r, with sign(r) = sign(a) for signed ops (truncating division).

Test Plan:
- DIV a=7, b=0xFFFFFFFE (-2), valid in cycle 0 → done=1 in cycle 34, y=0xFFFFFFFD (-3). REM on the same operands → y=1. REM a=0xFFFFFFF9 (-7), b=2 → y=0xFFFFFFFF.
- DIVU a=0xFFFFFFFF, b=0x10 → y=0x0FFFFFFF at cycle 34. REMU on the same operands → y=0xF. busy=1 in cycles 1..33, 0 in cycle 34.
- Divide by zero:
  - DIV a=5, b=0 → done in cycle 1, y=0xFFFFFFFF.
  - REMU a=0x12345678, b=0 → y=0x12345678.
  - busy stays 0 throughout.
- Overflow:
  - DIV a=0x80000000, b=0xFFFFFFFF → done in cycle 1, y=0x80000000.
  - REM on the same operands → y=0.
  - DIVU on the same operands is not a fast path → y=0 at cycle 34.
- flush_ex=1 in cycle 10 of a DIVU → state IDLE in cycle 11, no done pulse ever, y keeps its previous value. A new valid in cycle 11 completes normally in cycle 45.
- Back-to-back and reset:
  - valid asserted in the done cycle (cycle 34) is accepted → second done in cycle 68.
  - valid in cycle 5 while busy is ignored.
  - rst=0 in cycle 20 → y=0, done=0, busy=0 immediately.
